// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Multi-lane writeback stage with an integrated general-purpose register
//   file, bypassed read ports and a per-register busy scoreboard.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   interlock  1: hold; nothing commits this cycle
//   wb_valid   per-lane write request
//   wb_rd      per-lane destination register (lane i at [i*RW +: RW])
//   wb_data    per-lane write data (lane i at [i*XLEN +: XLEN])
//   iss_valid  per-lane issue: mark iss_rd busy
//   iss_rd     per-lane destination being issued
//   rd_addr    read addresses (port p at [p*RW +: RW])
//   rd_data    read data, combinational (port p at [p*XLEN +: XLEN])
//   rd_busy    1: register at rd_addr has a pending producer
//   conflict   registered pulse: two or more lanes committed to the same rd
//   retired    running count of committed lane writes, wraps at 2^32
// ---------------------------------------------------------------------------
module wb_regfile #(
   parameter int LANES   = 2,
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int RPORTS  = 4,
   parameter int ZERO_R0 = 1,
   parameter int BYPASS  = 1,
   localparam int RW     = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   interlock,
   input  logic [LANES-1:0]       wb_valid,
   input  logic [LANES*RW-1:0]    wb_rd,
   input  logic [LANES*XLEN-1:0]  wb_data,
   input  logic [LANES-1:0]       iss_valid,
   input  logic [LANES*RW-1:0]    iss_rd,
   input  logic [RPORTS*RW-1:0]   rd_addr,
   output logic [RPORTS*XLEN-1:0] rd_data,
   output logic [RPORTS-1:0]      rd_busy,
   output logic                   conflict,
   output logic [31:0]            retired
);

   localparam logic [RW:0] NREG_V = (RW+1)'(NREG);

   // Address lies inside the implemented register range (matters for non-power-of-2 NREG).
   function automatic logic addr_ok(input logic [RW-1:0] a);
      return ({1'b0, a} < NREG_V);
   endfunction

   // Address is the hardwired zero register.
   function automatic logic is_r0(input logic [RW-1:0] a);
      return (ZERO_R0 != 0) && (a == {RW{1'b0}});
   endfunction

   logic [XLEN-1:0]  gpr_r [NREG];
   logic [NREG-1:0]  busy_r;
   logic [NREG-1:0]  busy_n_s;
   logic             conflict_r;
   logic [31:0]      retired_r;

   logic [LANES-1:0] commit_s;    // lane performs a real commit this cycle
   logic [LANES-1:0] win_s;       // committing lane not overridden by a younger lane
   logic             conflict_s;
   logic [31:0]      ncommit_s;

   // Commit qualification, same-destination arbitration and commit count.
   always_comb begin
      commit_s   = {LANES{1'b0}};
      win_s      = {LANES{1'b0}};
      conflict_s = 1'b0;
      ncommit_s  = 32'd0;
      for (int i = 0; i < LANES; i++) begin
         commit_s[i] = wb_valid[i] & ~interlock
                       & ~is_r0(wb_rd[i*RW +: RW]) & addr_ok(wb_rd[i*RW +: RW]);
      end
      win_s = commit_s;
      // Younger (higher-index) lane wins; every older duplicate is dropped.
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (commit_s[i] && commit_s[j] && (wb_rd[i*RW +: RW] == wb_rd[j*RW +: RW])) begin
               win_s[i]   = 1'b0;
               conflict_s = 1'b1;
            end else begin
               win_s[i]   = win_s[i];
            end
         end
      end
      // Dropped duplicates still count as retired.
      for (int i = 0; i < LANES; i++) begin
         ncommit_s = ncommit_s + 32'(commit_s[i]);
      end
   end

   // Next scoreboard state: clear on commit, then set on issue so a newer producer wins.
   always_comb begin
      busy_n_s = busy_r;
      for (int i = 0; i < LANES; i++) begin
         if (commit_s[i]) begin
            busy_n_s[wb_rd[i*RW +: RW]] = 1'b0;
         end else begin
            busy_n_s = busy_n_s;
         end
      end
      for (int i = 0; i < LANES; i++) begin
         if (iss_valid[i] && !is_r0(iss_rd[i*RW +: RW]) && addr_ok(iss_rd[i*RW +: RW])) begin
            busy_n_s[iss_rd[i*RW +: RW]] = 1'b1;
         end else begin
            busy_n_s = busy_n_s;
         end
      end
   end

   // Register file storage: only arbitration winners write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            gpr_r[r] <= {XLEN{1'b0}};
         end
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (win_s[i]) begin
               gpr_r[wb_rd[i*RW +: RW]] <= wb_data[i*XLEN +: XLEN];
            end
         end
      end
   end

   // Scoreboard, conflict pulse and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r     <= {NREG{1'b0}};
         conflict_r <= 1'b0;
         retired_r  <= 32'd0;
      end else begin
         busy_r     <= busy_n_s;
         conflict_r <= conflict_s;
         retired_r  <= retired_r + ncommit_s;
      end
   end

   // Read ports: zero register / out-of-range, then same-cycle bypass, then storage.
   always_comb begin
      logic [RW-1:0] a;
      a       = {RW{1'b0}};
      rd_data = {(RPORTS*XLEN){1'b0}};
      rd_busy = {RPORTS{1'b0}};
      for (int p = 0; p < RPORTS; p++) begin
         a = rd_addr[p*RW +: RW];
         if (is_r0(a) || !addr_ok(a)) begin
            rd_data[p*XLEN +: XLEN] = {XLEN{1'b0}};
            rd_busy[p]              = 1'b0;
         end else begin
            rd_data[p*XLEN +: XLEN] = gpr_r[a];
            rd_busy[p]              = busy_r[a];
            // Ascending scan: the highest committing lane overrides older ones.
            for (int i = 0; i < LANES; i++) begin
               if ((BYPASS != 0) && commit_s[i] && (wb_rd[i*RW +: RW] == a)) begin
                  rd_data[p*XLEN +: XLEN] = wb_data[i*XLEN +: XLEN];
                  rd_busy[p]              = 1'b0;
               end else begin
                  rd_busy[p]              = rd_busy[p];
               end
            end
         end
      end
   end

   assign conflict = conflict_r;
   assign retired  = retired_r;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed, table-driven bench for wb_regfile with default parameters
//   (2 lanes, 32-bit, 32 registers, 4 read ports, r0 hardwired, bypass on).
//   Ports 0/2 read address a0 and ports 1/3 read address a1 of each vector.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

   logic         clk = 1'b0;
   logic         rst;
   logic         interlock;
   logic [1:0]   wb_valid;
   logic [9:0]   wb_rd;
   logic [63:0]  wb_data;
   logic [1:0]   iss_valid;
   logic [9:0]   iss_rd;
   logic [19:0]  rd_addr;
   logic [127:0] rd_data;
   logic [3:0]   rd_busy;
   logic         conflict;
   logic [31:0]  retired;

   int total = 0;
   int bad   = 0;

   wb_regfile dut (
      .clk       (clk),
      .rst       (rst),
      .interlock (interlock),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .conflict  (conflict),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        il;
      logic [1:0]  wv;
      logic [4:0]  r0;
      logic [31:0] d0;
      logic [4:0]  r1;
      logic [31:0] d1;
      logic [1:0]  iv;
      logic [4:0]  i0;
      logic [4:0]  i1;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] e_d0;
      logic        e_b0;
      logic [31:0] e_d1;
      logic        e_b1;
      logic [31:0] e_ret;
      logic        e_cf;
   } vec_t;

   vec_t vt [14];

   function automatic vec_t mk(
      input logic il, input logic [1:0] wv,
      input logic [4:0] r0, input logic [31:0] d0,
      input logic [4:0] r1, input logic [31:0] d1,
      input logic [1:0] iv, input logic [4:0] i0, input logic [4:0] i1,
      input logic [4:0] a0, input logic [4:0] a1,
      input logic [31:0] e_d0, input logic e_b0,
      input logic [31:0] e_d1, input logic e_b1,
      input logic [31:0] e_ret, input logic e_cf);
      vec_t v;
      v.il = il; v.wv = wv; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
      v.iv = iv; v.i0 = i0; v.i1 = i1; v.a0 = a0; v.a1 = a1;
      v.e_d0 = e_d0; v.e_b0 = e_b0; v.e_d1 = e_d1; v.e_b1 = e_b1;
      v.e_ret = e_ret; v.e_cf = e_cf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      interlock = 1'b0;
      wb_valid  = 2'b00;
      wb_rd     = 10'd0;
      wb_data   = 64'd0;
      iss_valid = 2'b00;
      iss_rd    = 10'd0;
   endtask

   task automatic apply(input vec_t v);
      interlock = v.il;
      wb_valid  = v.wv;
      wb_rd     = {v.r1, v.r0};
      wb_data   = {v.d1, v.d0};
      iss_valid = v.iv;
      iss_rd    = {v.i1, v.i0};
      rd_addr   = {v.a1, v.a0, v.a1, v.a0};
   endtask

   initial begin
      //        il    wv     r0     d0            r1     d1            iv     i0     i1     a0     a1     e_d0          e_b0  e_d1          e_b1  e_ret   e_cf
      vt[0]  = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b01, 5'd4, 5'd0, 5'd4, 5'd0, 32'h0,      1'b0, 32'h0,      1'b0, 32'd0, 1'b0);
      vt[1]  = mk(1'b0, 2'b11, 5'd3, 32'h11,      5'd5, 32'h22,      2'b00, 5'd0, 5'd0, 5'd3, 5'd4, 32'h11,     1'b0, 32'h0,      1'b1, 32'd2, 1'b0);
      vt[2]  = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd3, 5'd5, 32'h11,     1'b0, 32'h22,     1'b0, 32'd2, 1'b0);
      vt[3]  = mk(1'b0, 2'b11, 5'd7, 32'hAAAA,    5'd7, 32'hBBBB,    2'b00, 5'd0, 5'd0, 5'd7, 5'd5, 32'hBBBB,   1'b0, 32'h22,     1'b0, 32'd4, 1'b1);
      vt[4]  = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd7, 5'd9, 32'hBBBB,   1'b0, 32'h0,      1'b0, 32'd4, 1'b0);
      vt[5]  = mk(1'b0, 2'b01, 5'd9, 32'h1234,    5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd9, 5'd7, 32'h1234,   1'b0, 32'hBBBB,   1'b0, 32'd5, 1'b0);
      vt[6]  = mk(1'b1, 2'b11, 5'd9, 32'h5555,    5'd9, 32'h6666,    2'b01, 5'd9, 5'd0, 5'd9, 5'd4, 32'h1234,   1'b0, 32'h0,      1'b1, 32'd5, 1'b0);
      vt[7]  = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd9, 5'd4, 32'h1234,   1'b1, 32'h0,      1'b1, 32'd5, 1'b0);
      vt[8]  = mk(1'b0, 2'b01, 5'd4, 32'h44,      5'd0, 32'h0,       2'b01, 5'd4, 5'd0, 5'd4, 5'd9, 32'h44,     1'b0, 32'h1234,   1'b1, 32'd6, 1'b0);
      vt[9]  = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd4, 5'd0, 32'h44,     1'b1, 32'h0,      1'b0, 32'd6, 1'b0);
      vt[10] = mk(1'b0, 2'b01, 5'd0, 32'hFF,      5'd0, 32'h0,       2'b10, 5'd0, 5'd0, 5'd0, 5'd4, 32'h0,      1'b0, 32'h44,     1'b1, 32'd6, 1'b0);
      vt[11] = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd0, 5'd9, 32'h0,      1'b0, 32'h1234,   1'b1, 32'd6, 1'b0);
      vt[12] = mk(1'b0, 2'b10, 5'd0, 32'h0,       5'd9, 32'h99,      2'b00, 5'd0, 5'd0, 5'd9, 5'd3, 32'h99,     1'b0, 32'h11,     1'b0, 32'd7, 1'b0);
      vt[13] = mk(1'b0, 2'b00, 5'd0, 32'h0,       5'd0, 32'h0,       2'b00, 5'd0, 5'd0, 5'd9, 5'd4, 32'h99,     1'b0, 32'h44,     1'b1, 32'd7, 1'b0);

      // Power-on reset state.
      rst     = 1'b1;
      idle();
      rd_addr = {5'd3, 5'd2, 5'd1, 5'd0};
      @(posedge clk);
      @(negedge clk);
      chk("por_retired", retired, 32'd0);
      chk("por_conflict", {31'd0, conflict}, 32'd0);
      chk("por_rd_busy", {28'd0, rd_busy}, 32'd0);
      rst = 1'b0;

      // Table: combinational reads before the edge, registered outputs after it.
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         apply(vt[k]);
         #1;
         for (int p = 0; p < 4; p++) begin
            chk($sformatf("v%0d_data_p%0d", k, p), rd_data[p*32 +: 32], p[0] ? vt[k].e_d1 : vt[k].e_d0);
            chk($sformatf("v%0d_busy_p%0d", k, p), {31'd0, rd_busy[p]}, {31'd0, p[0] ? vt[k].e_b1 : vt[k].e_b0});
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_retired", k), retired, vt[k].e_ret);
         chk($sformatf("v%0d_conflict", k), {31'd0, conflict}, {31'd0, vt[k].e_cf});
      end

      // Retire counter wrap: preload near the top, then commit two lanes.
      @(negedge clk);
      idle();
      force dut.retired_r = 32'hFFFF_FFFF;
      #1;
      release dut.retired_r;
      #1;
      chk("wrap_preload", retired, 32'hFFFF_FFFF);
      wb_valid = 2'b11;
      wb_rd    = {5'd11, 5'd10};
      wb_data  = {32'h2, 32'h1};
      @(posedge clk);
      #1;
      chk("wrap_retired", retired, 32'd1);
      @(negedge clk);
      idle();
      rd_addr = {5'd0, 5'd0, 5'd11, 5'd10};
      #1;
      chk("wrap_r10", rd_data[31:0], 32'h1);
      chk("wrap_r11", rd_data[63:32], 32'h2);

      // Mid-run asynchronous reset with busy bits set and a commit in flight.
      iss_valid = 2'b11;
      iss_rd    = {5'd13, 5'd12};
      @(posedge clk);
      @(negedge clk);
      idle();
      rd_addr  = {5'd3, 5'd13, 5'd10, 5'd12};
      #1;
      chk("pre_rst_busy_r12", {31'd0, rd_busy[0]}, 32'd1);
      chk("pre_rst_busy_r13", {31'd0, rd_busy[2]}, 32'd1);
      wb_valid = 2'b01;
      wb_rd    = {5'd0, 5'd14};
      wb_data  = {32'h0, 32'hAB};
      #1;
      rst = 1'b1;
      #1;
      for (int p = 0; p < 4; p++) begin
         chk($sformatf("rst_data_p%0d", p), rd_data[p*32 +: 32], 32'd0);
      end
      chk("rst_rd_busy", {28'd0, rd_busy}, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_conflict", {31'd0, conflict}, 32'd0);
      @(posedge clk);
      #1;
      chk("rst_hold_retired", retired, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      rd_addr = {5'd5, 5'd10, 5'd12, 5'd14};
      #1;
      chk("post_rst_r14", rd_data[31:0], 32'd0);
      chk("post_rst_busy_r12", {31'd0, rd_busy[1]}, 32'd0);
      chk("post_rst_r10", rd_data[95:64], 32'd0);
      chk("post_rst_r5", rd_data[127:96], 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
